au_host_sequencer: RTL and testbench

Upstream command sequencer for the 16-bit arithmetic unit. It accepts one whole-word request (opcode, signedness, two operands) on a valid/ready port. It breaks the request into the unit's byte-wide load/execute/readback protocol by driving the unit's data byte and control byte. It returns the 16-bit result from register B with P/N flags on a valid/ready response port. This frees the host from bit-level sequencing of the unit's control pins.

---
 rtl/au_host_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_au_host_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/au_host_sequencer.sv
// Host-side sequencer for the 16-bit arithmetic unit.
// Takes one whole-word request and turns it into the unit's byte-wide protocol:
// load A/B, execute, read back B. It then returns the result and flags on a
// valid/ready response port.
module au_host_sequencer #(
    parameter int unsigned EXEC_CYCLES = 18,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic [1:0]  REQ_OP,
    input  logic        REQ_SIGNED,
    input  logic [15:0] REQ_A,
    input  logic [15:0] REQ_B,
    output logic        RSP_VALID,
    input  logic        RSP_READY,
    output logic [15:0] RSP_RESULT,
    output logic        RSP_P,
    output logic        RSP_N,
    output logic        RSP_ERR,
    output logic [7:0]  AU_DATA,
    output logic [7:0]  AU_CTRL,
    input  logic [7:0]  AU_Q,
    input  logic        AU_P,
    input  logic        AU_N,
    input  logic        AU_F,
    input  logic        AU_ERR
);

    localparam int unsigned CntMax = (EXEC_CYCLES > TIMEOUT) ? EXEC_CYCLES : TIMEOUT;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    typedef enum logic [3:0] {
        StIdle, StLdAl, StLdAh, StLdBl, StLdBh, StExec, StReadL, StReadH, StResp
    } state_e;

    state_e            state_q, state_d;
    logic              phase_q;     // 0 = first cycle of a 2-cycle step, 1 = second
    logic [CntW-1:0]   cnt_q;
    logic              f_seen_q;
    logic [1:0]        op_q;
    logic              signed_q;
    logic [15:0]       a_q;
    logic [15:0]       b_q;
    logic [15:0]       result_q;
    logic              p_q;
    logic              n_q;
    logic              err_q;

    logic              accept;
    logic              is_mul;
    logic              exec_last;
    logic              exec_timeout;

    assign accept = (state_q == StIdle) && REQ_VALID;
    assign is_mul = (op_q == 2'b11);

    // ADD/SUB run a fixed count; MUL runs one cycle past the first AU_F.
    assign exec_last = (state_q == StExec) &&
                       (is_mul ? f_seen_q : (cnt_q == CntW'(EXEC_CYCLES - 1)));
    assign exec_timeout = (state_q == StExec) && is_mul && !f_seen_q && !AU_F &&
                          (cnt_q == CntW'(TIMEOUT - 1));

    // State register with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StLdAl;
            StLdAl:  if (phase_q) state_d = StLdAh;
            StLdAh:  if (phase_q) state_d = StLdBl;
            StLdBl:  if (phase_q) state_d = StLdBh;
            StLdBh:  if (phase_q) state_d = StExec;
            StExec: begin
                if (exec_last) begin
                    state_d = StReadL;
                end else if (exec_timeout) begin
                    state_d = StResp;
                end
            end
            StReadL: if (phase_q) state_d = StReadH;
            StReadH: if (phase_q) state_d = StResp;
            StResp:  if (RSP_READY) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Request latch, step counters, readback capture and sticky error.
    always_ff @(posedge CLK) begin
        if (RST) begin
            phase_q  <= 1'b0;
            cnt_q    <= '0;
            f_seen_q <= 1'b0;
            op_q     <= 2'b00;
            signed_q <= 1'b0;
            a_q      <= 16'h0000;
            b_q      <= 16'h0000;
            result_q <= 16'h0000;
            p_q      <= 1'b0;
            n_q      <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if ((state_q != StIdle) && AU_ERR) begin
                err_q <= 1'b1;
            end
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        // Reserved opcode 00 executes as ADD.
                        op_q     <= (REQ_OP == 2'b00) ? 2'b01 : REQ_OP;
                        signed_q <= REQ_SIGNED;
                        a_q      <= REQ_A;
                        b_q      <= REQ_B;
                        result_q <= 16'h0000;
                        p_q      <= 1'b0;
                        n_q      <= 1'b0;
                        err_q    <= 1'b0;
                        phase_q  <= 1'b0;
                        cnt_q    <= '0;
                        f_seen_q <= 1'b0;
                    end
                end
                StLdAl, StLdAh, StLdBl, StLdBh: begin
                    phase_q <= ~phase_q;
                end
                StExec: begin
                    cnt_q <= cnt_q + CntW'(1);
                    if (is_mul && AU_F) begin
                        f_seen_q <= 1'b1;
                    end
                    if (exec_last) begin
                        p_q   <= AU_P;
                        n_q   <= AU_N;
                        cnt_q <= '0;
                    end
                    if (exec_timeout) begin
                        err_q    <= 1'b1;
                        result_q <= 16'h0000;
                    end
                end
                StReadL: begin
                    phase_q <= ~phase_q;
                    if (phase_q) result_q[7:0] <= AU_Q;
                end
                StReadH: begin
                    phase_q <= ~phase_q;
                    if (phase_q) result_q[15:8] <= AU_Q;
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from state; C stays at the latched signedness all transaction.
    always_comb begin
        REQ_READY  = (state_q == StIdle);
        RSP_VALID  = (state_q == StResp);
        RSP_RESULT = result_q;
        RSP_P      = p_q;
        RSP_N      = n_q;
        RSP_ERR    = err_q;
        AU_DATA    = 8'h00;
        AU_CTRL    = 8'h00;
        unique case (state_q)
            StIdle: ;
            StLdAl: begin
                AU_DATA = a_q[7:0];
                AU_CTRL = {signed_q, 2'b00, 2'b00, 1'b1, ~phase_q, 1'b0};
            end
            StLdAh: begin
                AU_DATA = a_q[15:8];
                AU_CTRL = {signed_q, 2'b00, 2'b01, 1'b1, ~phase_q, 1'b0};
            end
            StLdBl: begin
                AU_DATA = is_mul ? 8'h00 : b_q[7:0];
                AU_CTRL = {signed_q, 2'b00, 2'b10, 1'b1, ~phase_q, 1'b0};
            end
            StLdBh: begin
                AU_DATA = is_mul ? 8'h00 : b_q[15:8];
                AU_CTRL = {signed_q, 2'b00, 2'b11, 1'b1, ~phase_q, 1'b0};
            end
            StExec: begin
                AU_DATA = is_mul ? b_q[7:0] : 8'h00;
                AU_CTRL = {signed_q, op_q, 2'b00, 1'b1, 1'b1, 1'b0};
            end
            StReadL: AU_CTRL = {signed_q, 2'b00, 2'b10, 3'b000};
            StReadH: AU_CTRL = {signed_q, 2'b00, 2'b11, 3'b000};
            StResp:  AU_CTRL = {signed_q, 7'b0000000};
            default: ;
        endcase
    end

endmodule

// File: tb/tb_au_host_sequencer.sv
// Bench for au_host_sequencer: a behavioural arithmetic-unit stub answers the
// byte protocol, and an integer reference model predicts each response.
module tb_au_host_sequencer;

    localparam int unsigned EXEC_CYCLES = 18;
    localparam int unsigned TIMEOUT     = 255;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        REQ_VALID = 1'b0;
    logic        REQ_READY;
    logic [1:0]  REQ_OP = 2'b00;
    logic        REQ_SIGNED = 1'b0;
    logic [15:0] REQ_A = 16'h0000;
    logic [15:0] REQ_B = 16'h0000;
    logic        RSP_VALID;
    logic        RSP_READY = 1'b0;
    logic [15:0] RSP_RESULT;
    logic        RSP_P, RSP_N, RSP_ERR;
    logic [7:0]  AU_DATA, AU_CTRL, AU_Q;
    logic        AU_ERR = 1'b0;

    int checks = 0;
    int errors = 0;
    int mul_lat = 0;     // stub MUL latency in S cycles; 0 = AU_F never rises

    always #5 CLK = ~CLK;

    au_host_sequencer #(.EXEC_CYCLES(EXEC_CYCLES), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RST(RST),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_OP(REQ_OP),
        .REQ_SIGNED(REQ_SIGNED), .REQ_A(REQ_A), .REQ_B(REQ_B),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RESULT(RSP_RESULT),
        .RSP_P(RSP_P), .RSP_N(RSP_N), .RSP_ERR(RSP_ERR),
        .AU_DATA(AU_DATA), .AU_CTRL(AU_CTRL), .AU_Q(AU_Q),
        .AU_P(up), .AU_N(un), .AU_F(uf), .AU_ERR(AU_ERR)
    );

    // ---------------- arithmetic unit stub ----------------
    logic [15:0] ua = 16'h0000;
    logic [15:0] ub = 16'h0000;
    int          ucnt = 0;
    logic        uf = 1'b0, up = 1'b0, un = 1'b0;

    // Returns {P, N, result} for B op A (MUL: B + A*M).
    function automatic logic [17:0] au_exec(input logic [1:0] op, input logic sg,
                                            input logic [15:0] a, input logic [15:0] b,
                                            input logic [7:0] m);
        logic [16:0] s17;
        logic [31:0] prod, sum;
        logic [16:0] top;
        logic [15:0] r;
        logic        p;
        case (op)
            2'b10: begin
                r = b - a;
                p = sg ? ((b[15] != a[15]) && (r[15] != b[15])) : (a > b);
            end
            2'b11: begin
                prod = sg ? ({{16{a[15]}}, a} * {{24{m[7]}}, m}) : ({16'h0, a} * {24'h0, m});
                sum  = {{16{sg & b[15]}}, b} + prod;
                r    = sum[15:0];
                top  = sum[31:15];
                p    = sg ? !((top == 17'h0) || (top == 17'h1FFFF)) : (sum[31:16] != 16'h0);
            end
            default: begin
                s17 = {1'b0, a} + {1'b0, b};
                r   = s17[15:0];
                p   = sg ? ((a[15] == b[15]) && (r[15] != b[15])) : s17[16];
            end
        endcase
        return {p, sg & r[15], r};
    endfunction

    always @(posedge CLK) begin : au_stub
        if (AU_CTRL[1] && AU_CTRL[2] && AU_CTRL[6:5] == 2'b00) begin
            case (AU_CTRL[4:3])
                2'b00: ua[7:0]  <= AU_DATA;
                2'b01: ua[15:8] <= AU_DATA;
                2'b10: ub[7:0]  <= AU_DATA;
                default: ub[15:8] <= AU_DATA;
            endcase
        end
        if (AU_CTRL[1] && AU_CTRL[2] && AU_CTRL[6:5] != 2'b00) begin
            ucnt <= ucnt + 1;
            if (ucnt + 1 == ((AU_CTRL[6:5] == 2'b11) ? mul_lat : 16)) begin
                {up, un, ub} <= au_exec(AU_CTRL[6:5], AU_CTRL[7], ua, ub, AU_DATA);
                uf <= 1'b1;
            end
        end else begin
            ucnt <= 0;
            uf   <= 1'b0;
        end
    end

    assign AU_Q = AU_CTRL[4] ? (AU_CTRL[3] ? ub[15:8] : ub[7:0])
                             : (AU_CTRL[3] ? ua[15:8] : ua[7:0]);

    // ---------------- reference model (plain integer arithmetic) ----------------
    task automatic model(input logic [1:0] op, input logic sg, input logic [15:0] a,
                         input logic [15:0] b, output logic [15:0] r, output logic p,
                         output logic n);
        longint av, bv, mv, v;
        av = (sg && a[15]) ? longint'(a) - 65536 : longint'(a);
        bv = (sg && b[15]) ? longint'(b) - 65536 : longint'(b);
        mv = (sg && b[7]) ? longint'(b[7:0]) - 256 : longint'(b[7:0]);
        if (op == 2'b11) v = av * mv;
        else if (op == 2'b10) v = bv - av;
        else v = bv + av;
        r = v[15:0];
        p = sg ? (v < -32768 || v > 32767) : (v < 0 || v > 65535);
        n = sg && r[15];
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One full transaction with latency, protocol and response checks.
    task automatic run_txn(input logic [1:0] op, input logic sg, input logic [15:0] a,
                           input logic [15:0] b, input int lat, input int err_at,
                           input int bp, input string tag);
        logic [15:0] mr, r0;
        logic        mp, mn, is_mul, to;
        int exp_lat, exp_execs, exp_reads, n, reads, execs, cbad, dbad, bad;
        logic [7:0] exp_data;
        model(op, sg, a, b, mr, mp, mn);
        is_mul    = (op == 2'b11);
        to        = is_mul && (lat == 0 || lat >= int'(TIMEOUT));
        exp_lat   = to ? 8 + TIMEOUT : (is_mul ? 8 + (lat + 1) + 1 + 4 : 8 + EXEC_CYCLES + 4);
        exp_execs = to ? TIMEOUT : (is_mul ? lat + 2 : EXEC_CYCLES);
        exp_reads = to ? 0 : 4;
        exp_data  = is_mul ? b[7:0] : 8'h00;
        mul_lat   = lat;

        chk({tag, ":req_ready"}, REQ_READY, 1'b1);
        REQ_OP = op; REQ_SIGNED = sg; REQ_A = a; REQ_B = b; REQ_VALID = 1'b1;
        tick();
        REQ_VALID = 1'b0;
        REQ_OP = 2'($urandom); REQ_SIGNED = 1'($urandom);
        REQ_A = 16'($urandom); REQ_B = 16'($urandom);

        n = 0; reads = 0; execs = 0; cbad = 0; dbad = 0;
        while (RSP_VALID !== 1'b1 && n < 400) begin
            if (AU_CTRL[7] !== sg) cbad++;
            if (AU_CTRL[4] && !AU_CTRL[2]) reads++;
            if (AU_CTRL[6:5] != 2'b00 && AU_CTRL[2] && AU_CTRL[1]) begin
                execs++;
                if (AU_DATA !== exp_data) dbad++;
            end
            AU_ERR = (err_at > 0 && n == err_at);
            tick();
            n++;
        end
        AU_ERR = 1'b0;

        chk({tag, ":latency"}, n, exp_lat);
        chk({tag, ":result"}, RSP_RESULT, to ? 16'h0000 : mr);
        chk({tag, ":p"}, RSP_P, to ? 1'b0 : mp);
        chk({tag, ":n"}, RSP_N, to ? 1'b0 : mn);
        chk({tag, ":err"}, RSP_ERR, to || err_at > 0);
        chk({tag, ":reads"}, reads, exp_reads);
        chk({tag, ":exec_cycles"}, execs, exp_execs);
        chk({tag, ":c_const"}, cbad, 0);
        chk({tag, ":exec_data"}, dbad, 0);
        chk({tag, ":ready_busy"}, REQ_READY, 1'b0);

        // Backpressure with a competing request that must not be taken in RESP.
        r0 = RSP_RESULT; bad = 0;
        RSP_READY = 1'b0;
        if (bp > 0) REQ_VALID = 1'b1;
        for (int i = 0; i < bp; i++) begin
            tick();
            if (!(RSP_VALID === 1'b1 && RSP_RESULT === r0 && REQ_READY === 1'b0 &&
                  AU_CTRL[7] === sg && RSP_ERR === (to || err_at > 0))) bad++;
        end
        if (bp > 0) chk({tag, ":bp_stable"}, bad, 0);
        RSP_READY = 1'b1;
        tick();
        RSP_READY = 1'b0;
        REQ_VALID = 1'b0;
        chk({tag, ":idle_after"}, {REQ_READY, RSP_VALID}, 2'b10);
    endtask

    initial begin
        int quiet;
        // Reset state
        repeat (3) tick();
        chk("rst:ready_valid", {REQ_READY, RSP_VALID}, 2'b10);
        chk("rst:result", RSP_RESULT, 16'h0000);
        chk("rst:flags", {RSP_P, RSP_N, RSP_ERR}, 3'b000);
        chk("rst:au", {AU_DATA, AU_CTRL}, 16'h0000);
        RST = 1'b0;
        tick();

        // AU_ERR while idle must not be recorded.
        AU_ERR = 1'b1;
        tick();
        AU_ERR = 1'b0;
        chk("idle_err_ignored", RSP_ERR, 1'b0);

        run_txn(2'b01, 1'b0, 16'h1234, 16'h0101, 0, 0, 0, "add_u");
        run_txn(2'b10, 1'b1, 16'h0007, 16'h0005, 0, 0, 0, "sub_s");
        run_txn(2'b11, 1'b0, 16'h0012, 16'hAB10, 5, 0, 0, "mul_u");
        run_txn(2'b11, 1'b0, 16'h0012, 16'h0010, 0, 0, 0, "mul_timeout");
        run_txn(2'b01, 1'b0, 16'hFFFF, 16'h0002, 0, 0, 10, "add_bp");
        run_txn(2'b01, 1'b0, 16'h0100, 16'h0023, 0, 0, 0, "add_after_bp");
        run_txn(2'b11, 1'b1, 16'hFFFD, 16'h0005, 254, 0, 0, "mul_f_last");
        run_txn(2'b11, 1'b1, 16'hFFFD, 16'h0005, 255, 0, 0, "mul_f_late");
        run_txn(2'b10, 1'b0, 16'h0003, 16'h0009, 0, 3, 0, "sub_au_err");
        run_txn(2'b10, 1'b0, 16'h0003, 16'h0009, 0, 0, 0, "err_cleared");
        run_txn(2'b00, 1'b1, 16'h7FFF, 16'h0001, 0, 0, 0, "rsv_op");

        // Reset during LD_BL drops the request.
        REQ_OP = 2'b01; REQ_SIGNED = 1'b1; REQ_A = 16'h1111; REQ_B = 16'h2222;
        REQ_VALID = 1'b1;
        tick();
        REQ_VALID = 1'b0;
        repeat (4) tick();
        chk("rst_mid:in_ld_bl", {AU_CTRL[4:3], AU_CTRL[2]}, 3'b101);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("rst_mid:ready_valid", {REQ_READY, RSP_VALID}, 2'b10);
        chk("rst_mid:au", {AU_DATA, AU_CTRL}, 16'h0000);
        chk("rst_mid:rsp", {RSP_RESULT, RSP_P, RSP_N, RSP_ERR}, 19'h0);
        quiet = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (RSP_VALID !== 1'b0 || REQ_READY !== 1'b1) quiet++;
        end
        chk("rst_mid:no_rsp", quiet, 0);
        run_txn(2'b01, 1'b0, 16'h0001, 16'h0001, 0, 0, 0, "add_after_rst");

        // Randomized transactions
        for (int i = 0; i < 12; i++) begin
            logic [1:0]  op;
            logic        sg;
            logic [15:0] a, b;
            int lat, err_at, bp;
            op     = 2'($urandom_range(0, 3));
            sg     = 1'($urandom_range(0, 1));
            a      = 16'($urandom);
            b      = 16'($urandom);
            lat    = int'($urandom_range(1, 40));
            err_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 12)) : 0;
            bp     = int'($urandom_range(0, 3));
            run_txn(op, sg, a, b, lat, err_at, bp, $sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
